// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a
// shift-count FSM that flags a fully shifted-out word. Rotate support via UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic [WIDTH-1:0]             d,
   input  logic                         sin_l,
   input  logic                         sin_r,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   input  logic                         rot,
`endif
   output logic [WIDTH-1:0]             q,
   output logic                         sout_r,
   output logic                         sout_l,
   output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
   output logic                         done
);

   localparam int unsigned CW = $clog2(WIDTH+1);

   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   q_d;
   logic [CW-1:0]      cnt_d;
   logic               done_d;
   logic               fill_l, fill_r;
   logic               load, shift;

   // State, data and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         q         <= RESET_VAL;
         shift_cnt <= '0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         q         <= q_d;
         shift_cnt <= cnt_d;
         done      <= done_d;
      end
   end

   // Next datapath value and shift-tracking FSM
   always_comb begin
      q_d     = q;
      state_d = state_q;
      cnt_d   = shift_cnt;
      fill_l  = sin_l;
      fill_r  = sin_r;
      load    = en && (mode == MODE_LOAD);
      shift   = en && ((mode == MODE_SHR) || (mode == MODE_SHL));

`ifdef UNIV_SHIFT_REG_ROTATE_EN
      if (rot) begin
         fill_l = q[0];
         fill_r = q[WIDTH-1];
      end
`endif

      if (en) begin
         case (mode)
            MODE_SHR:  q_d = {fill_l, q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q[WIDTH-2:0], fill_r};
            MODE_LOAD: q_d = d;
            default:   q_d = q;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = ACTIVE;
               cnt_d   = '0;
            end
         end
         ACTIVE: begin
            if (load) begin
               cnt_d = '0;
            end else if (shift) begin
               cnt_d = shift_cnt + CW'(1);
               if (shift_cnt == CW'(WIDTH - 1)) state_d = DONE;
            end
         end
         DONE: begin
            // count stays saturated at WIDTH until the next load
            if (load) begin
               state_d = ACTIVE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      done_d = (state_d == DONE);
   end

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit register bank with four modes: hold, shift right, shift left and parallel load.
- A shift-tracking state machine flags when a loaded word has been fully shifted out.
- Used as a serializer/deserializer front-end and as a general-purpose pipeline register in datapath blocks.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  clock enable; 0 = every register holds.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB during shift right.
- sin_r  input  1  serial input entering at the LSB during shift left.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0]; combinational from q.
- sout_l  output  1  q[WIDTH-1]; combinational from q.
- shift_cnt  output  $clog2(WIDTH+1)  shifts since the last load; saturates at WIDTH.
- done  output  1  high while the FSM is in DONE.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - q = RESET_VAL, shift_cnt = 0, done = 0, state = IDLE.
  - Asserting rst mid-shift aborts the sequence. No update occurs on an edge while rst is high.
- Datapath, on a rising edge with en=1:
  - mode 00: q holds.
  - mode 01: q <= {sin_l, q[WIDTH-1:1]}.
  - mode 10: q <= {q[WIDTH-2:0], sin_r}.
  - mode 11: q <= d.
- en=0 overrides mode: q, shift_cnt and state all hold.
- Latency: one cycle from the edge to the q update. sout_l and sout_r follow q with no extra delay.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE: shifts update q but are not counted and shift_cnt stays 0. A load goes to ACTIVE.
  - ACTIVE: each shift (mode 01 or 10 with en=1) increments shift_cnt. When the increment makes shift_cnt equal WIDTH, go to DONE on the same edge. A load stays in ACTIVE with shift_cnt = 0.
  - DONE: done=1. Further shifts still update q while shift_cnt holds at WIDTH. A load goes to ACTIVE with shift_cnt = 0 and done = 0 on that edge.
- Hold (mode 00) never changes state or shift_cnt.
- Shift direction is not tracked: mixed left and right shifts both count.
- Load and shift cannot occur together because mode is one-hot in effect. Load always restarts the count.
- done and shift_cnt are registered outputs with no combinational path from the inputs.

Optional Feature:
- Macro: UNIV_SHIFT_REG_ROTATE_EN.
- With the macro defined:
  - An extra input rot (1 bit) is added after sin_r.
  - When rot=1, mode 01 gives q <= {q[0], q[WIDTH-1:1]} and mode 10 gives q <= {q[WIDTH-2:0], q[WIDTH-1]`; sin_l and sin_r are ignored.
  - Rotations count toward shift_cnt exactly like shifts.
- Without the macro: the rot port is absent and shifts always take sin_l or sin_r.

Test Plan (WIDTH=8, RESET_VAL=8'h00):
- Reset: rst=1 pulsed between edges → q=8'h00, shift_cnt=0 and done=0 immediately, without waiting for an edge.
- Serialize: load d=8'hA5, then 8 shift-right edges with sin_l=0 → sout_r sequence 1,0,1,0,0,1,0,1; done rises on the 8th edge; q=8'h00; shift_cnt=8.
- Deserialize: load d=8'h00, then shift left 8 times with sin_r sequence 1,1,0,0,1,0,1,1 → q=8'hCB, done=1. A 9th shift gives shift_cnt=8 (saturated), done=1, q=8'h97 with sin_r=1.
- Enable and hold: load 8'h3C, shift twice, then mode=01 with en=0 for 3 edges, then mode=00 for 2 edges → q=8'h0F (sin_l=0), shift_cnt=2, done=0 throughout.
- Reload and abort:
  - Load 8'hFF, shift 5 times, reload 8'h12 → shift_cnt=0 and q=8'h12 on that edge.
  - Shift 3 times, then assert rst → state returns to IDLE.
  - Shifts while in IDLE leave shift_cnt=0.
- Rotate (macro defined): load 8'h81, rot=1, mode=10 for 1 edge → q=8'h03, sin_r ignored. Mode=01 for 2 edges → q=8'hC0, shift_cnt=3.
